control_r: RTL and testbench

Receive-side packet steering stage between the PHY RX stream and the link layer; the counterpart of the transmit-side mux. Accepts byte beats from the PHY on a valid/ready interface, classifies each packet by its PID byte (first beat), and forwards it through a one-deep registered output stage:
- token and handshake packets go to the CRC5 checker path;
- data packets go to the link-layer data path.

Packets whose PID fails its check or is a special type are consumed and dropped, and the block reports an error pulse.

---
 rtl/control_r.sv | 140 ++++++++++++++
 tb/tb_control_r.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_r.sv
// Receive-side packet steering: classifies PHY packets by PID and forwards them
// through a one-deep registered stage to either the token/handshake or the data path.
module control_r (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_lp_sop,
    input  logic       rx_lp_eop,
    input  logic       rx_lp_valid,
    output logic       rx_lp_ready,
    input  logic [7:0] rx_lp_data,
    output logic       rx_to_sop,
    output logic       rx_to_eop,
    output logic       rx_to_valid,
    input  logic       rx_to_ready,
    output logic [7:0] rx_to_data,
    output logic       rx_lt_sop,
    output logic       rx_lt_eop,
    output logic       rx_lt_valid,
    input  logic       rx_lt_ready,
    output logic [7:0] rx_lt_data,
    output logic       rx_data_on,
    output logic       rx_pid_err,
    output logic       rx_frame_err,
    output logic       rx_lp_eop_en
);

    localparam int unsigned DataW = 8;

    typedef enum logic [1:0] {IDLE, TO, LT, DROP} state_e;

    state_e             state_q, state_d;
    state_e             sop_dest;
    logic               vld_q, vld_d;
    logic               sel_q, sel_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               out_rdy;
    logic               acc;
    logic               pid_ok;
    logic               fwd;
    logic               fwd_sel;

    // A new beat may enter only when the held beat is absent or leaving this cycle,
    // so a held beat never changes path.
    assign out_rdy     = sel_q ? rx_lt_ready : rx_to_ready;
    assign rx_lp_ready = ~vld_q | out_rdy;
    assign acc         = rx_lp_valid & rx_lp_ready;
    assign pid_ok      = (rx_lp_data[7:4] == ~rx_lp_data[3:0]);

    // PID classification of the current byte
    always_comb begin
        sop_dest = DROP;
        if (pid_ok) begin
            case (rx_lp_data[1:0])
                2'b01, 2'b10: sop_dest = TO;
                2'b11:        sop_dest = LT;
                default:      sop_dest = DROP;
            endcase
        end
    end

    // Next-state, forwarding decision and event pulses
    always_comb begin
        state_d      = state_q;
        fwd          = 1'b0;
        fwd_sel      = 1'b0;
        rx_pid_err   = 1'b0;
        rx_frame_err = 1'b0;
        rx_lp_eop_en = acc & rx_lp_eop;
        if (acc) begin
            if (rx_lp_sop) begin
                rx_frame_err = (state_q != IDLE);
                rx_pid_err   = (sop_dest == DROP);
                fwd          = (sop_dest != DROP);
                fwd_sel      = (sop_dest == LT);
                state_d      = rx_lp_eop ? IDLE : sop_dest;
            end else begin
                case (state_q)
                    TO, LT: begin
                        fwd     = 1'b1;
                        fwd_sel = (state_q == LT);
                        if (rx_lp_eop) state_d = IDLE;
                    end
                    DROP: begin
                        if (rx_lp_eop) state_d = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output stage: drain on handshake, reload on every forwarded beat
    always_comb begin
        vld_d  = vld_q;
        sel_d  = sel_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        data_d = data_q;
        if (vld_q & out_rdy) vld_d = 1'b0;
        if (fwd) begin
            vld_d  = 1'b1;
            sel_d  = fwd_sel;
            sop_d  = rx_lp_sop;
            eop_d  = rx_lp_eop;
            data_d = rx_lp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            sel_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            sel_q   <= sel_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    assign rx_to_valid = vld_q & ~sel_q;
    assign rx_lt_valid = vld_q & sel_q;
    assign rx_to_sop   = sop_q;
    assign rx_lt_sop   = sop_q;
    assign rx_to_eop   = eop_q;
    assign rx_lt_eop   = eop_q;
    assign rx_to_data  = data_q;
    assign rx_lt_data  = data_q;
    assign rx_data_on  = (state_q == LT);

endmodule

// File: tb/tb_control_r.sv
// Bench for control_r: directed packets plus random traffic checked against a
// packet-level model of routing, holding and event pulses.
module tb_control_r;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_lp_sop, rx_lp_eop, rx_lp_valid, rx_lp_ready;
    logic [7:0] rx_lp_data;
    logic       rx_to_sop, rx_to_eop, rx_to_valid, rx_to_ready;
    logic [7:0] rx_to_data;
    logic       rx_lt_sop, rx_lt_eop, rx_lt_valid, rx_lt_ready;
    logic [7:0] rx_lt_data;
    logic       rx_data_on, rx_pid_err, rx_frame_err, rx_lp_eop_en;

    always #5 clk = ~clk;

    control_r dut (
        .clk(clk), .rst_n(rst_n),
        .rx_lp_sop(rx_lp_sop), .rx_lp_eop(rx_lp_eop), .rx_lp_valid(rx_lp_valid),
        .rx_lp_ready(rx_lp_ready), .rx_lp_data(rx_lp_data),
        .rx_to_sop(rx_to_sop), .rx_to_eop(rx_to_eop), .rx_to_valid(rx_to_valid),
        .rx_to_ready(rx_to_ready), .rx_to_data(rx_to_data),
        .rx_lt_sop(rx_lt_sop), .rx_lt_eop(rx_lt_eop), .rx_lt_valid(rx_lt_valid),
        .rx_lt_ready(rx_lt_ready), .rx_lt_data(rx_lt_data),
        .rx_data_on(rx_data_on), .rx_pid_err(rx_pid_err),
        .rx_frame_err(rx_frame_err), .rx_lp_eop_en(rx_lp_eop_en)
    );

    int tests = 0;
    int fails = 0;

    // Model: the beat waiting downstream, and where the open packet is going
    // (0 none, 1 token/handshake path, 2 data path, 3 being dropped).
    bit         m_hv, m_hsel, m_hsop, m_heop;
    logic [7:0] m_hd;
    int         m_open;
    int         lt_stall;
    bit         rand_rdy;
    logic [7:0] pkt[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [7:0] d);
        if (d[7:4] != ~d[3:0]) return 3;
        case (d[1:0])
            2'b01, 2'b10: return 1;
            2'b11:        return 2;
            default:      return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_hv = 0; m_hsel = 0; m_hsop = 0; m_heop = 0; m_hd = '0; m_open = 0;
    endtask

    // One clock: drive, check at negedge, advance the model after the posedge.
    task automatic tick(input bit v, input bit s, input bit e, input logic [7:0] d,
                        output bit accepted);
        bit tr, lr, exp_rdy, acc, fwd, fsel, pid_e, fr_e;
        int cls, next_open;
        tr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        lr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (lt_stall > 0) begin
            lr = 1'b0;
            lt_stall--;
        end
        rx_lp_valid = v; rx_lp_sop = s; rx_lp_eop = e; rx_lp_data = d;
        rx_to_ready = tr; rx_lt_ready = lr;
        @(negedge clk);
        exp_rdy = !m_hv || (m_hsel ? lr : tr);
        acc     = v && exp_rdy;
        chk("lp_ready", 8'(rx_lp_ready), 8'(exp_rdy));
        chk("to_valid", 8'(rx_to_valid), 8'(m_hv && !m_hsel));
        chk("lt_valid", 8'(rx_lt_valid), 8'(m_hv && m_hsel));
        if (m_hv) begin
            chk("to_sop", 8'(rx_to_sop), 8'(m_hsop));
            chk("lt_sop", 8'(rx_lt_sop), 8'(m_hsop));
            chk("to_eop", 8'(rx_to_eop), 8'(m_heop));
            chk("lt_eop", 8'(rx_lt_eop), 8'(m_heop));
            chk("to_data", rx_to_data, m_hd);
            chk("lt_data", rx_lt_data, m_hd);
        end
        chk("data_on", 8'(rx_data_on), 8'(m_open == 2));
        pid_e = 0; fr_e = 0; fwd = 0; fsel = 0; next_open = m_open;
        if (acc) begin
            if (s) begin
                cls       = classify(d);
                fr_e      = (m_open != 0);
                pid_e     = (cls == 3);
                fwd       = (cls != 3);
                fsel      = (cls == 2);
                next_open = e ? 0 : cls;
            end else if (m_open == 1 || m_open == 2) begin
                fwd  = 1;
                fsel = (m_open == 2);
                if (e) next_open = 0;
            end else if (m_open == 3 && e) begin
                next_open = 0;
            end
        end
        chk("pid_err", 8'(rx_pid_err), 8'(pid_e));
        chk("frame_err", 8'(rx_frame_err), 8'(fr_e));
        chk("eop_en", 8'(rx_lp_eop_en), 8'(acc && e));
        @(posedge clk);
        #1;
        if (m_hv && (m_hsel ? lr : tr)) m_hv = 0;
        if (fwd) begin
            m_hv = 1; m_hsel = fsel; m_hsop = s; m_heop = e; m_hd = d;
        end
        m_open   = next_open;
        accepted = acc;
    endtask

    task automatic send_beat(input bit s, input bit e, input logic [7:0] d);
        bit got;
        int n;
        got = 0;
        n   = 0;
        while (!got && n < 50) begin
            tick(1'b1, s, e, d, got);
            n++;
        end
        tests++;
        assert (got) else begin
            fails++;
            $error("FAIL accept_timeout observed=%0d cycles expected=accept data=%0h", n, d);
        end
    endtask

    task automatic send_pkt(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++)
            send_beat(i == 0, i == b.size() - 1, b[i]);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_lp_ready"}, 8'(rx_lp_ready), 8'd1);
        chk({tag, "_to_valid"}, 8'(rx_to_valid), 8'd0);
        chk({tag, "_lt_valid"}, 8'(rx_lt_valid), 8'd0);
        chk({tag, "_to_data"}, rx_to_data, 8'd0);
        chk({tag, "_data_on"}, 8'(rx_data_on), 8'd0);
        chk({tag, "_sop"}, 8'({rx_to_sop, rx_to_eop, rx_lt_sop, rx_lt_eop}), 8'd0);
    endtask

    initial begin
        logic [7:0] pick[6];
        bit a, v, s, e;
        logic [7:0] d;
        pick = '{8'hA5, 8'hC3, 8'hD2, 8'hA4, 8'hF0, 8'hE1};
        rst_n = 1'b0; rx_lp_valid = 0; rx_lp_sop = 0; rx_lp_eop = 0; rx_lp_data = '0;
        rx_to_ready = 1; rx_lt_ready = 1;
        lt_stall = 0; rand_rdy = 0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Token packet
        pkt = '{8'hA5, 8'h83, 8'hA0}; send_pkt(pkt); idle(2);
        // Data packet
        pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44}; send_pkt(pkt); idle(2);
        // Bad PID, then special PID
        pkt = '{8'hA4, 8'h00, 8'h00}; send_pkt(pkt); idle(1);
        pkt = '{8'hF0, 8'h5A}; send_pkt(pkt); idle(1);
        // Data path stalled mid-packet
        send_beat(1, 0, 8'hC3); send_beat(0, 0, 8'h11);
        lt_stall = 3;
        send_beat(0, 0, 8'h22); send_beat(0, 1, 8'h33); idle(2);
        // Single-beat handshake
        send_beat(1, 1, 8'hD2); idle(2);
        // Truncation: handshake sop arrives while a data beat is held
        send_beat(1, 0, 8'hC3); send_beat(0, 0, 8'h11);
        lt_stall = 2;
        send_beat(1, 1, 8'hD2); idle(2);
        // Stray non-sop beats in IDLE are discarded
        send_beat(0, 0, 8'h77); send_beat(0, 1, 8'h78); idle(1);

        // Async reset mid-packet
        send_beat(1, 0, 8'hC3); send_beat(0, 0, 8'h55);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(1);

        // Random traffic with random downstream readiness
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 3) == 0);
            e = 1'($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 8'($urandom);
            tick(v, s, e, d, a);
        end
        rand_rdy = 0;
        idle(3);
        chk("final_empty", 8'(rx_to_valid | rx_lt_valid), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
